conv2c_arbiter: RTL and testbench

CONV2C_ARBITER -- requirements
Module: conv2c_arbiter

---
 rtl/conv2c_arbiter.sv | 126 ++++++++++++
 tb/tb_conv2c_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv2c_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : conv2c_arbiter
//  Purpose  : Round-robin sharing of one 34-bit sign-magnitude to
//             two's-complement converter among 4 requesters, with a single
//             registered output stage (valid/ready, one cycle latency).
//  Options  : CONV2C_SAT_EN - when defined, results saturate to the signed
//             34-bit range instead of wrapping modulo 2^34.
//  Revision : 1.0 - initial release
// ============================================================================
module conv2c_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [135:0] req_mag,
    input  logic [3:0]   req_sign,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [33:0]  out_data,
    output logic [1:0]   out_id,
    input  logic         out_ready
);

    // Pointer value after reset: the search begins at ptr+1, so requester 0
    // holds first priority.
    localparam logic [1:0]  c_PTR_RESET = 2'd3;
    localparam logic [33:0] c_POS_MAX   = 34'h1_FFFF_FFFF;
    localparam logic [33:0] c_NEG_MIN   = 34'h2_0000_0000;

    logic        r_out_valid;
    logic [33:0] r_out_data;
    logic [1:0]  r_out_id;
    logic [1:0]  r_ptr;

    logic        w_slot_free;
    logic        w_grant_found;
    logic [1:0]  w_grant;
    logic [1:0]  w_idx;
    logic [3:0]  w_ready;
    logic        w_transfer;
    logic [33:0] w_sel_mag;
    logic        w_sel_sign;
    logic [33:0] w_negated;
    logic [33:0] w_result;

    assign w_slot_free = ~r_out_valid | out_ready;

    // Round-robin search: first valid requester starting at ptr+1, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = 2'd0;
        w_idx         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant       = w_idx;
            end
        end
    end

    // Ready goes only to the winner, only when the output slot can take it,
    // and never while reset is asserted.
    always_comb begin
        w_ready = 4'b0000;
        if (!rst && w_slot_free && w_grant_found) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign req_ready  = w_ready;
    assign w_transfer = |(req_valid & w_ready);

    // Operand mux: only the granted requester's inputs reach the converter.
    always_comb begin
        w_sel_mag  = req_mag[33:0];
        w_sel_sign = req_sign[0];
        case (w_grant)
            2'd0:    begin w_sel_mag = req_mag[33:0];    w_sel_sign = req_sign[0]; end
            2'd1:    begin w_sel_mag = req_mag[67:34];   w_sel_sign = req_sign[1]; end
            2'd2:    begin w_sel_mag = req_mag[101:68];  w_sel_sign = req_sign[2]; end
            default: begin w_sel_mag = req_mag[135:102]; w_sel_sign = req_sign[3]; end
        endcase
    end

    assign w_negated = ~w_sel_mag + 34'd1;

    // Shared conversion unit (optionally saturating).
    always_comb begin
`ifdef CONV2C_SAT_EN
        if (!w_sel_sign && w_sel_mag[33]) begin
            w_result = c_POS_MAX;
        end else if (w_sel_sign && (w_sel_mag >= c_NEG_MIN)) begin
            w_result = c_NEG_MIN;
        end else begin
            w_result = w_sel_sign ? w_negated : w_sel_mag;
        end
`else
        w_result = w_sel_sign ? w_negated : w_sel_mag;
`endif
    end

    // Output register and pointer: load on transfer, drain on out_ready,
    // hold otherwise; reset wins over a simultaneous transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 34'd0;
            r_out_id    <= 2'd0;
            r_ptr       <= c_PTR_RESET;
        end else if (w_transfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_id    <= w_grant;
            r_ptr       <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_conv2c_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2c_arbiter
//  Purpose  : Self-checking bench for conv2c_arbiter: directed scenarios
//             followed by randomized traffic against a behavioural model.
//  Options  : CONV2C_SAT_EN - must match the build of the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv2c_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [135:0] req_mag;
    logic [3:0]   req_sign;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [33:0]  out_data;
    logic [1:0]   out_id;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_ptr   = 3;
    logic        m_valid = 1'b0;
    logic [33:0] m_data  = '0;
    logic [1:0]  m_id    = '0;

    conv2c_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mag   (req_mag),
        .req_sign  (req_sign),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed value of the operand, clamped when saturation is built in,
    // then reduced to 34-bit two's complement.
    function automatic logic [33:0] ref_conv(input logic [33:0] mag, input logic sign);
        longint v;
        longint lim;
        lim = 64'sh2_0000_0000;
        v   = sign ? -longint'({30'd0, mag}) : longint'({30'd0, mag});
`ifdef CONV2C_SAT_EN
        if (v > lim - 1) v = lim - 1;
        if (v < -lim)    v = -lim;
`endif
        return v[33:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [33:0] mag, input logic sign);
        req_mag[34*i +: 34] = mag;
        req_sign[i]         = sign;
    endtask

    // One cycle: inputs already driven; check ready, clock, check outputs.
    task automatic step(input string tag);
        int          g;
        logic [3:0]  exp_ready;
        g         = -1;
        exp_ready = 4'b0000;
        if (!rst && (!m_valid || out_ready)) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        #1;
        chk({tag, ".ready"}, {60'd0, req_ready}, {60'd0, exp_ready});
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = '0; m_ptr = 3;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = ref_conv(req_mag[34*g +: 34], req_sign[g]);
            m_id    = 2'(g);
            m_ptr   = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid || rst) begin
            chk({tag, ".data"}, {30'd0, out_data}, {30'd0, m_data});
            chk({tag, ".id"},   {62'd0, out_id},   {62'd0, m_id});
        end
    endtask

    logic [33:0] rmag;
    logic [1:0]  id_seq [5];

    initial begin
        rst = 1'b1; req_valid = '0; req_mag = '0; req_sign = '0; out_ready = 1'b0;
        @(negedge clk);
        step("reset");
        chk("reset.ptr_data", {30'd0, out_data}, 64'd0);
        rst = 1'b0;

        // Single request, mag=5 negative
        req_valid = 4'b0001; out_ready = 1'b1;
        set_req(0, 34'd5, 1'b1);
        step("single");
        chk("single.value", {30'd0, out_data}, 64'h3_FFFF_FFFB);
        chk("single.id", {62'd0, out_id}, 64'd0);

        // Round-robin fairness with all four requesting
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 34'(100 + i), 1'b0);
        rst = 1'b1; step("rr_rst"); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            id_seq[i] = out_id;
        end
        chk("rr.seq0", {62'd0, id_seq[0]}, 64'd0);
        chk("rr.seq1", {62'd0, id_seq[1]}, 64'd1);
        chk("rr.seq2", {62'd0, id_seq[2]}, 64'd2);
        chk("rr.seq3", {62'd0, id_seq[3]}, 64'd3);
        chk("rr.seq4", {62'd0, id_seq[4]}, 64'd0);

        // Backpressure: output held, requester 1 waits
        req_valid = 4'b0010; out_ready = 1'b0;
        set_req(1, 34'h1234, 1'b0);
        for (int i = 0; i < 3; i++) step("bp_hold");
        chk("bp.stable", {30'd0, out_data}, 64'd100);
        out_ready = 1'b1;
        step("bp_release");
        chk("bp.accept", {30'd0, out_data}, 64'h1234);

        // Reset mid-operation, then 1010 grants requester 1 first
        req_valid = 4'b1010;
        rst = 1'b1;
        step("midrst");
        chk("midrst.data", {30'd0, out_data}, 64'd0);
        rst = 1'b0;
        step("post_rst");
        chk("post_rst.id", {62'd0, out_id}, 64'd1);

        // Saturation boundary and zero case
        req_valid = 4'b0100;
        set_req(2, 34'h2_0000_0001, 1'b1);
        step("satb");
`ifdef CONV2C_SAT_EN
        chk("satb.value", {30'd0, out_data}, 64'h2_0000_0000);
`else
        chk("satb.value", {30'd0, out_data}, 64'h1_FFFF_FFFF);
`endif
        set_req(2, 34'h2_0000_0000, 1'b1);
        step("satx");
        chk("satx.value", {30'd0, out_data}, 64'h2_0000_0000);
        set_req(2, 34'd0, 1'b1);
        step("zero");
        chk("zero.value", {30'd0, out_data}, 64'd0);
        req_valid = 4'b0000;
        step("idle");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(49, 0) == 0);
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(7, 0))
                    0:       rmag = 34'd0;
                    1:       rmag = 34'h2_0000_0000;
                    2:       rmag = 34'h2_0000_0001;
                    3:       rmag = 34'h3_FFFF_FFFF;
                    4:       rmag = 34'h1_FFFF_FFFF;
                    default: rmag = {2'($urandom), 32'($urandom)};
                endcase
                set_req(i, rmag, 1'($urandom));
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
